// File: rtl/cereal_rx_if.sv
// ============================================================================
// Module      : cereal_rx_if
// Description : Read-side bus of the cereal receiver FIFO (pop + head byte).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cereal_rx_if;
    logic       rd_en;
    logic [7:0] data_out;
    logic       data_valid;

    modport master (
        output rd_en,
        input  data_out,
        input  data_valid
    );

    modport slave (
        input  rd_en,
        output data_out,
        output data_valid
    );
endinterface

`default_nettype wire

// File: rtl/cereal_rx.sv
// ============================================================================
// Module      : cereal_rx
// Description : 8N1 serial receiver, mid-bit sampled, with a small FWFT FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cereal_rx #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int FIFO_AW      = 2
) (
    input  wire logic   sysclk,
    input  wire logic   reset,
    input  wire logic   serialIn,
    cereal_rx_if.slave  rx,
    output logic        frame_err,
    output logic        overrun,
    output logic        busy,
    output logic        rx_debug
);

    localparam int CW    = $clog2(CLKS_PER_BIT);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int NW    = FIFO_AW + 1;

    localparam logic [CW-1:0] C_LAST    = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] C_HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [NW-1:0] C_DEPTH   = NW'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    logic [1:0]    sync_q;
    logic          rxs;
    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bitn_q;
    logic [7:0]    shift_q;
    logic          frame_err_q;
    logic          push;

    logic [7:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0] rd_ptr_q;
    logic [FIFO_AW-1:0] wr_ptr_q;
    logic [NW-1:0]      count_q;
    logic [NW-1:0]      count_d;
    logic               overrun_q;
    logic               do_pop;
    logic               do_push;
    logic               drop;

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], serialIn};
        end
    end

    assign rxs = sync_q[1];

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bitn_q      <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (!rxs) begin
                        cnt_q   <= '0;
                        state_q <= S_START;
                    end
                end
                S_START: begin
                    if (cnt_q == C_HALF_M1) begin
                        if (!rxs) begin
                            cnt_q   <= '0;
                            bitn_q  <= '0;
                            state_q <= S_DATA;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_DATA: begin
                    if (cnt_q == C_LAST) begin
                        cnt_q           <= '0;
                        shift_q[bitn_q] <= rxs;
                        if (bitn_q == 3'd7) begin
                            state_q <= S_STOP;
                        end else begin
                            bitn_q <= bitn_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_STOP: begin
                    if (cnt_q == C_LAST) begin
                        cnt_q <= '0;
                        if (rxs) begin
                            state_q <= S_IDLE;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= S_BREAK;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_BREAK: begin
                    // Hold off until the line returns high so a stuck-low line cannot retrigger.
                    if (rxs) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign push = (state_q == S_STOP) && (cnt_q == C_LAST) && rxs;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts the push.
    always_comb begin
        do_pop  = rx.rd_en && (count_q != '0);
        do_push = push && ((count_q != C_DEPTH) || do_pop);
        drop    = push && (count_q == C_DEPTH) && !do_pop;
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + NW'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - NW'(1);
        end
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= shift_q;
                wr_ptr_q        <= wr_ptr_q + FIFO_AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
            end
            if (drop) begin
                overrun_q <= 1'b1;
            end
            count_q <= count_d;
        end
    end

    assign rx.data_out   = mem_q[rd_ptr_q];
    assign rx.data_valid = (count_q != '0);
    assign frame_err     = frame_err_q;
    assign overrun       = overrun_q;
    assign busy          = (state_q != S_IDLE);
    assign rx_debug      = rxs;

endmodule

`default_nettype wire

// File: doc/cereal_rx.md
Name: cereal_rx

Overview:
- UART-style serial receiver; the receiving end of the `cereal` transmitter protocol (idle-high line, 1 start bit low, 8 data bits LSB first, 1 stop bit high).
- Replaces ad-hoc bit sampling in the top level with a synchronised, mid-bit-sampled receiver.
- Received bytes go into a small first-word-fall-through FIFO.
- The top level pops bytes with `rd_en`, then stores or echoes them through `cereal`.

Parameters:
- CLKS_PER_BIT, 5208, sysclk cycles per bit (50 MHz / 9600 baud); minimum 4.
- FIFO_AW, 2, FIFO address width; depth = 2**FIFO_AW = 4 bytes.

Ports:
- sysclk  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-low reset.
- serialIn  in  1  asynchronous serial line, idle high.
- rd_en  in  1  pop the head byte; ignored when data_valid=0.
- data_out  out  8  FIFO head byte; valid only while data_valid=1.
- data_valid  out  1  FIFO not empty.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  sticky: a byte was dropped because the FIFO was full.
- busy  out  1  high whenever the FSM is not in IDLE.
- rx_debug  out  1  synchronised serialIn, for a scope pin.

Behaviour:
- Reset (reset=0, asynchronous): FSM to IDLE; FIFO empty; bit and clock counters 0; synchroniser flops set to 1.
- Output values during reset: data_out=0, data_valid=0, frame_err=0, overrun=0, busy=0, rx_debug=1.
- Synchroniser: serialIn passes through 2 flops to give `rxs`. rx_debug = rxs. All decisions use rxs, so input-to-decision latency is 2 cycles.
- FSM states: IDLE, START, DATA, STOP, BREAK. One cycle counter `cnt` and one bit index `bitn` (0..7).
- IDLE: when rxs=0, load cnt=0 and go to START.
- START: count to CLKS_PER_BIT/2 − 1 (integer division), i.e. the start-bit centre.
  - rxs still 0 → cnt=0, bitn=0, go to DATA.
  - rxs=1 → glitch; return to IDLE with no output.
- DATA: every CLKS_PER_BIT cycles (cnt wraps at CLKS_PER_BIT−1), shift rxs into shift register bit position bitn (LSB first).
  - After bitn=7 is sampled, go to STOP.
- STOP: after CLKS_PER_BIT cycles, sample rxs.
  - rxs=1 → push the byte (subject to the FIFO rules below); go to IDLE.
  - rxs=0 → frame_err high for exactly 1 cycle; byte discarded; go to BREAK.
- BREAK: wait for rxs=1, then go to IDLE. Prevents re-triggering on a held-low line.
- Receive timing: the byte is pushed in the cycle of the stop-bit sample, about 9.5 bit times after the synchronised falling edge. data_valid rises the following cycle.
- FIFO: FIFO_AW-bit wrapping read and write pointers plus an occupancy count of FIFO_AW+1 bits.
  - data_out = mem[rd_ptr], combinational (first-word fall-through).
  - Pop: rd_en=1 and count>0 → rd_ptr+1 (wraps). rd_en with count=0 is ignored and has no side effect.
  - Push when count < depth → stored.
  - Push when full with no simultaneous pop → byte dropped, overrun set to 1.
  - Push and pop in the same cycle while full → both proceed; count stays at depth; no overrun.
  - Push and pop in the same cycle while empty → push proceeds; count becomes 1; the pop is ignored.
- overrun is cleared only by reset. Sticky so software can detect the loss.
- Pointer wrap-around from index depth−1 to 0 must preserve byte order.
- busy = (state != IDLE).
- Reset mid-frame: the partial byte is discarded; no frame_err and no push occur.

Test Plan (CLKS_PER_BIT=16):
- Send 0x41 at 16 clocks/bit → data_valid rises; data_out=0x41. Pulse rd_en → data_valid=0. frame_err and overrun remain 0.
- Low glitch of 5 cycles on the idle line → FSM returns to IDLE. No push; data_valid stays 0; busy high for at most 8+2 cycles.
- Send 0x55 with the stop bit driven low, then hold the line low for 40 cycles, then release high → one frame_err pulse; no push; FSM stays in BREAK until high.
- Then send 0x0F → received correctly.
- Send 0x01..0x05 with no reads → first 4 bytes stored; overrun=1 after the 5th.
  - Reads return 0x01,0x02,0x03,0x04, then data_valid=0.
- Fill the FIFO with 0x10..0x13, then assert rd_en in the same cycle as the push of 0x14 → overrun stays 0.
  - Subsequent reads return 0x11,0x12,0x13,0x14, confirming pointer wrap.
- Assert reset mid-way through DATA bit 4 → all outputs return to reset values immediately.
  - Release reset, then send 0xA5 → data_out=0xA5.
